// File: rtl/q_maze_pkg.sv
// q_maze_pkg: shared maze geometry, sequencer FSM encoding and grid adjacency check
package q_maze_pkg;
    localparam int STATE_W    = 6;
    localparam int NUM_STATES = 37;
    localparam int COLS       = 6;

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_CMD, S_MOVING, S_COMPLETE, S_ARRIVED, S_FAULT
    } seq_state_e;

    function automatic logic is_adjacent(state_t a, state_t b);
        int ra, ca, rb, cb;
        ra = int'(a) / COLS;
        ca = int'(a) % COLS;
        rb = int'(b) / COLS;
        cb = int'(b) % COLS;
        return int'(a) < NUM_STATES && int'(b) < NUM_STATES &&
               ((ra == rb && (ca - cb == 1 || cb - ca == 1)) ||
                (ca == cb && (ra - rb == 1 || rb - ra == 1)));
    endfunction
endpackage

// File: rtl/q_move_sequencer_timer.sv
// move_timer: loadable down-counter timing one physical move of MOVE_CYCLES cycles
module move_timer #(
    parameter int MOVE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    output logic busy_o,
    output logic expire_o
);
    localparam int CW = MOVE_CYCLES > 1 ? $clog2(MOVE_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          act_q;

    assign busy_o   = act_q;
    assign expire_o = act_q && cnt_q == '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            act_q <= 1'b0;
            cnt_q <= '0;
        end else if (clear_i) begin
            act_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            act_q <= 1'b1;
            cnt_q <= CW'(MOVE_CYCLES - 1);
        end else if (expire_o) begin
            act_q <= 1'b0;
        end else if (act_q) begin
            cnt_q <= cnt_q - 1'b1;
        end
endmodule

// File: rtl/q_move_sequencer.sv
// q_move_sequencer: validates, times and logs maze moves commanded by the exploit stage
module q_move_sequencer
    import q_maze_pkg::*;
#(
    parameter int MOVE_CYCLES = 1000,
    parameter int MAX_STEPS   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done,
    input  logic [STATE_W-1:0] start_state,
    input  logic [STATE_W-1:0] target_state,
    input  logic [STATE_W-1:0] next_state,
    input  logic               timer_start,
    output logic [STATE_W-1:0] maze_state,
    output logic               move_complete,
    output logic               at_target,
    output logic               fault,
    output logic [STATE_W:0]   step_count,
    input  logic [STATE_W-1:0] path_rd_addr,
    output logic [STATE_W-1:0] path_rd_data
);
    localparam int LW = $clog2(MAX_STEPS + 1);
    localparam int SW = STATE_W + 1;

    seq_state_e         state_q, state_d;
    logic [STATE_W-1:0] maze_q, maze_d, pend_q, pend_d, rd_q, log_val;
    logic [SW-1:0]      step_q, step_d;
    logic               mc_q, mc_d, at_q, at_d, flt_q, flt_d;
    logic               log_we, timer_busy, timer_expire, accept, legal;
    logic [LW-1:0]      log_idx;
    // One extra entry so the move that reaches the step limit is still logged
    logic [STATE_W-1:0] log_q [MAX_STEPS+1];

    assign accept = state_q == S_WAIT_CMD && timer_start && done && !timer_busy;
    assign legal  = int'(next_state) < NUM_STATES && is_adjacent(maze_q, next_state) &&
                    step_q < SW'(MAX_STEPS);

    move_timer #(.MOVE_CYCLES(MOVE_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept && legal),
        .clear_i  (!done),
        .busy_o   (timer_busy),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d = state_q;
        maze_d  = maze_q;
        step_d  = step_q;
        pend_d  = pend_q;
        mc_d    = 1'b0;
        at_d    = at_q;
        flt_d   = flt_q;
        log_we  = 1'b0;
        log_idx = '0;
        log_val = start_state;
        if (state_q != S_IDLE && !done) begin
            state_d = S_IDLE;
            at_d    = 1'b0;
            flt_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = done ? S_LOAD : S_IDLE;
                S_LOAD: begin
                    maze_d  = start_state;
                    step_d  = '0;
                    log_we  = 1'b1;
                    at_d    = start_state == target_state;
                    state_d = at_d ? S_ARRIVED : S_WAIT_CMD;
                end
                S_WAIT_CMD: if (accept) begin
                    pend_d  = next_state;
                    flt_d   = !legal;
                    state_d = legal ? S_MOVING : S_FAULT;
                end
                S_MOVING: if (timer_expire) begin
                    maze_d  = pend_q;
                    step_d  = step_q + 1'b1;
                    mc_d    = 1'b1;
                    log_we  = 1'b1;
                    log_idx = LW'(step_q + 1'b1);
                    log_val = pend_q;
                    at_d    = pend_q == target_state;
                    state_d = S_COMPLETE;
                end
                S_COMPLETE: state_d = at_q ? S_ARRIVED : S_WAIT_CMD;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= S_IDLE;
            maze_q  <= '0;
            pend_q  <= '0;
            step_q  <= '0;
            mc_q    <= 1'b0;
            at_q    <= 1'b0;
            flt_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            maze_q  <= maze_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            mc_q    <= mc_d;
            at_q    <= at_d;
            flt_q   <= flt_d;
            rd_q    <= ({1'b0, path_rd_addr} <= SW'(MAX_STEPS)) ? log_q[LW'(path_rd_addr)] : '0;
        end

    always_ff @(posedge clk)
        if (log_we) log_q[log_idx] <= log_val;

    assign maze_state    = maze_q;
    assign move_complete = mc_q;
    assign at_target     = at_q;
    assign fault         = flt_q;
    assign step_count    = step_q;
    assign path_rd_data  = rd_q;
endmodule

// File: tb/tb_q_move_sequencer.sv
// tb_q_move_sequencer: scoreboard bench for move timing, legality, logging, abort and reset
module tb_q_move_sequencer;
    localparam int M  = 4;
    localparam int MS = 4;

    typedef struct {
        logic [5:0] maze;
        int         step;
        logic       at;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b0, done = 1'b0, timer_start = 1'b0;
    logic       move_complete, at_target, fault;
    logic [5:0] start_state = '0, target_state = '0, next_state = '0, path_rd_addr = '0;
    logic [5:0] maze_state, path_rd_data;
    logic [6:0] step_count;
    int         cyc = 0, n_chk = 0, n_err = 0, m_step = 0;
    logic [5:0] m_maze = '0, m_target = '0;
    exp_t       sb[$];

    q_move_sequencer #(.MOVE_CYCLES(M), .MAX_STEPS(MS)) dut (
        .clk           (clk),
        .rst           (rst),
        .done          (done),
        .start_state   (start_state),
        .target_state  (target_state),
        .next_state    (next_state),
        .timer_start   (timer_start),
        .maze_state    (maze_state),
        .move_complete (move_complete),
        .at_target     (at_target),
        .fault         (fault),
        .step_count    (step_count),
        .path_rd_addr  (path_rd_addr),
        .path_rd_data  (path_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (rst && move_complete) begin
            exp_t e;
            if (sb.size() == 0) chk("mc_spurious", 1, 0);
            else begin
                e = sb.pop_front();
                chk("mc_cycle", cyc, e.cyc);
                chk("mc_maze", maze_state, e.maze);
                chk("mc_step", step_count, e.step);
                chk("mc_at", at_target, e.at);
            end
        end

    task automatic go(input logic [5:0] s, input logic [5:0] t);
        done = 1'b0;
        @(negedge clk);
        start_state  = s;
        target_state = t;
        done         = 1'b1;
        m_maze       = s;
        m_step       = 0;
        m_target     = t;
        repeat (2) @(negedge clk);
        chk("go_maze", maze_state, s);
        chk("go_step", step_count, 0);
    endtask

    task automatic move(input logic [5:0] s);
        next_state  = s;
        timer_start = 1'b1;
        sb.push_back('{s, m_step + 1, s == m_target, cyc + 1 + M});
        m_maze = s;
        m_step++;
        @(negedge clk);
        timer_start = 1'b0;
        repeat (M + 1) @(negedge clk);
    endtask

    task automatic bad(input logic [5:0] s, input string tag);
        next_state  = s;
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        chk(tag, fault, 1);
        chk({tag, "_maze"}, maze_state, m_maze);
    endtask

    task automatic rd(input int a, input logic [5:0] e);
        path_rd_addr = 6'(a);
        @(negedge clk);
        chk("log_rd", path_rd_data, e);
    endtask

    initial begin
        #12;
        chk("rst_maze", maze_state, 0);
        chk("rst_mc", move_complete, 0);
        chk("rst_at", at_target, 0);
        chk("rst_fault", fault, 0);
        chk("rst_step", step_count, 0);
        chk("rst_rd", path_rd_data, 0);
        @(negedge clk);
        rst = 1'b1;

        go(0, 2);
        move(1);
        move(2);
        chk("arr_at", at_target, 1);
        chk("arr_step", step_count, 2);
        chk("arr_maze", maze_state, 2);
        rd(0, 0);
        rd(1, 1);
        rd(2, 2);
        next_state  = 3;
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        repeat (M + 2) @(negedge clk);
        chk("arr_hold_maze", maze_state, 2);
        chk("arr_hold_fault", fault, 0);

        go(5, 0);
        bad(6, "row_end");
        repeat (3) @(negedge clk);
        chk("fault_hold", fault, 1);
        done = 1'b0;
        @(negedge clk);
        chk("fault_clr", fault, 0);
        chk("fault_keep_maze", maze_state, 5);

        go(5, 0);
        bad(40, "oob");
        go(36, 30);
        move(30);
        chk("s36_at", at_target, 1);
        chk("s36_maze", maze_state, 30);

        go(0, 2);
        move(1);
        next_state  = 2;
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("abort_step", step_count, 1);
        chk("abort_maze", maze_state, 1);
        chk("abort_at", at_target, 0);
        repeat (M + 2) @(negedge clk);
        go(3, 20);

        next_state  = 4;
        timer_start = 1'b1;
        sb.push_back('{6'd4, 1, 1'b0, cyc + 1 + M});
        m_maze = 4;
        m_step = 1;
        @(negedge clk);
        timer_start = 1'b0;
        @(negedge clk);
        next_state  = 9;
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        repeat (M - 1) @(negedge clk);
        chk("ign_fault", fault, 0);
        chk("ign_maze", maze_state, 4);
        chk("ign_sb", sb.size(), 0);

        go(0, 20);
        move(1);
        move(0);
        move(1);
        move(0);
        bad(1, "step_limit");
        chk("limit_step", step_count, MS);
        rd(0, 0);
        rd(1, 1);
        rd(2, 0);
        rd(3, 1);
        rd(4, 0);

        path_rd_addr = 1;
        go(3, 20);
        next_state  = 4;
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        @(negedge clk);
        chk("pre_rst_maze", maze_state, 3);
        chk("pre_rst_rd", path_rd_data, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_maze", maze_state, 0);
        chk("arst_mc", move_complete, 0);
        chk("arst_at", at_target, 0);
        chk("arst_fault", fault, 0);
        chk("arst_step", step_count, 0);
        chk("arst_rd", path_rd_data, 0);
        @(negedge clk);
        rst  = 1'b1;
        done = 1'b0;
        repeat (M + 2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
